led_seq_checker: RTL and testbench
==================================

Name: led_seq_checker

Overview:
- Receive-side monitor for the LED shift-register output.
- Samples the LED bus and the advance strobe that drives the shift register, locks onto the one-hot rotating pattern, and checks every advance against the expected rotation.
- Counts good steps and errors and raises a sticky error flag.
- Sits beside the counter/shift-register pair; outputs go to VIO/ILA probes for on-board self-check.

Parameters:
- NB_LEDS, 4: width of the LED bus under check.
- NB_STEPCNT, 16: width of the good-step counter (wraps).
- NB_ERRCNT, 8: width of the error counter (saturates).
- ROT_LEFT, 1: 1 = expect rotate-left {led[N-2:0],led[N-1]}; 0 = rotate-right {led[0],led[N-1:1]}.

Ports:
- clock  in  1  system clock, all state on rising edge.
- i_reset  in  1  asynchronous, active-low reset.
- i_led  in  NB_LEDS  LED bus being checked.
- i_valid  in  1  advance strobe, same pulse that shifts the register.
- i_clear  in  1  synchronous clear of error flag and both counters.
- o_locked  out  1  checker is tracking a valid pattern.
- o_error  out  1  sticky error flag.
- o_error_pulse  out  1  one-cycle pulse per detected error.
- o_step_count  out  NB_STEPCNT  number of correct advances, wraps.
- o_err_count  out  NB_ERRCNT  number of errors, saturates at all-ones.
- o_expected  out  NB_LEDS  pattern expected after the next advance.

Behaviour:
- Reset: all outputs 0, state IDLE, held pattern 0, valid_d 0.
- Timing:
  - valid_d is i_valid registered one cycle.
  - The shift register updates on the edge where i_valid=1, so the new pattern is checked on the following edge (valid_d=1).
  - Latency: a check completes 2 edges after i_valid is sampled; outputs are registered.
- IDLE:
  - If valid_d=1 and i_led is one-hot: held<=i_led, o_locked<=1, go TRACK.
  - Otherwise (not one-hot, including 0) stay in IDLE; no error is counted.
- TRACK, valid_d=1:
  - If i_led == rot(held): held<=i_led and step_count+1.
  - Otherwise it is an error (see below).
- TRACK, valid_d=0:
  - i_led must equal held.
  - Any change is an error (glitch or unstrobed shift).
- Error event:
  - o_error<=1 (sticky), o_error_pulse<=1 for exactly one cycle, err_count+1 saturating.
  - o_locked<=0, go IDLE.
  - Relock needs a later valid_d with a one-hot i_led.
- o_expected = rot(held) while in TRACK; 0 in IDLE.
- Consecutive i_valid on back-to-back cycles: each is checked independently against the updated held value.
- i_clear=1:
  - Same edge: o_error<=0, step_count<=0, err_count<=0.
  - State, held and o_locked are unaffected.
  - If an error event happens on the same edge, the error wins: o_error=1, err_count=1, step_count=0.
  - If a good step happens on the same edge: step_count=1.
- Counter limits: step_count wraps from all-ones to 0. err_count holds at all-ones with no further change; o_error_pulse still fires.
- Reset asserted mid-operation: immediate return to reset values, regardless of clock.
- Two states, IDLE and TRACK; encoding free.

Test Plan:
1. Lock and track: NB_LEDS=4, ROT_LEFT=1.
   - Stimulus: i_led=0001 with a valid pulse, then valid pulses with 0010, 0100, 1000, 0001.
   - Response: o_locked=1 after the first check, o_step_count=4, o_error=0, o_expected=0010 at the end.
2. Wrong step:
   - Stimulus: locked on 0010; next valid delivers 1000.
   - Response: o_error_pulse high 1 cycle, o_error=1, o_err_count=1, o_locked=0, o_expected=0.
   - Follow-up: a valid with 0100 relocks (o_locked=1), and o_error stays 1.
3. Glitch without strobe:
   - Stimulus: locked on 0100; i_led changes to 0110 with i_valid=0 for 1 cycle.
   - Response: error event, o_err_count increments, relock required.
4. Non-one-hot in IDLE:
   - Stimulus: valid pulses with i_led=0000 and 0011.
   - Response: o_locked stays 0, o_err_count stays 0.
5. Clear vs. error collision:
   - Setup: o_err_count=3.
   - Stimulus: i_clear asserted on the same edge as a mismatch.
   - Response: o_err_count=1, o_error=1, o_step_count=0.
6. Saturation, wrap and reset:
   - NB_ERRCNT=2: force 5 errors -> o_err_count=3, with 5 pulses seen.
   - NB_STEPCNT=2: 5 good steps -> o_step_count=1.
   - Assert i_reset=0 mid-track: all outputs 0 asynchronously.

Source files
------------

// File: rtl/led_seq_checker.sv
// led_seq_checker: locks onto a rotating one-hot LED pattern and checks every advance
module led_seq_checker #(
    parameter int NB_LEDS    = 4,
    parameter int NB_STEPCNT = 16,
    parameter int NB_ERRCNT  = 8,
    parameter bit ROT_LEFT   = 1'b1
) (
    input  logic                  clock,
    input  logic                  i_reset,
    input  logic [NB_LEDS-1:0]    i_led,
    input  logic                  i_valid,
    input  logic                  i_clear,
    output logic                  o_locked,
    output logic                  o_error,
    output logic                  o_error_pulse,
    output logic [NB_STEPCNT-1:0] o_step_count,
    output logic [NB_ERRCNT-1:0]  o_err_count,
    output logic [NB_LEDS-1:0]    o_expected
);
    typedef enum logic {IDLE, TRACK} state_t;
    state_t state, next_state;
    logic [NB_LEDS-1:0] held, rot_held;
    logic valid_d, one_hot, lock, good, bad;

    // Pattern the held value turns into after one advance
    always_comb rot_held = ROT_LEFT ? {held[NB_LEDS-2:0], held[NB_LEDS-1]} : {held[0], held[NB_LEDS-1:1]};

    // State register
    always_ff @(posedge clock or negedge i_reset)
        if (!i_reset) state <= IDLE;
        else          state <= next_state;

    // Classify the current sample and pick the next state; errors only exist while tracking
    always_comb begin
        one_hot    = (i_led != '0) && ((i_led & (i_led - NB_LEDS'(1))) == '0);
        lock       = (state == IDLE) && valid_d && one_hot;
        good       = (state == TRACK) && valid_d && (i_led == rot_held);
        bad        = (state == TRACK) && (valid_d ? (i_led != rot_held) : (i_led != held));
        next_state = lock ? TRACK : bad ? IDLE : state;
    end

    // Strobe delay, held pattern and lock flag; the strobe is checked one edge later, once the register has shifted
    always_ff @(posedge clock or negedge i_reset)
        if (!i_reset) begin
            valid_d  <= 1'b0;
            held     <= '0;
            o_locked <= 1'b0;
        end else begin
            valid_d  <= i_valid;
            held     <= (lock || good) ? i_led : held;
            o_locked <= (next_state == TRACK);
        end

    // Error flag, pulse and counters; an error or good step on a clear edge still counts once
    always_ff @(posedge clock or negedge i_reset)
        if (!i_reset) begin
            o_error       <= 1'b0;
            o_error_pulse <= 1'b0;
            o_step_count  <= '0;
            o_err_count   <= '0;
        end else begin
            o_error_pulse <= bad;
            o_error       <= bad ? 1'b1 : i_clear ? 1'b0 : o_error;
            o_step_count  <= i_clear ? NB_STEPCNT'(good) : o_step_count + NB_STEPCNT'(good);
            o_err_count   <= i_clear ? NB_ERRCNT'(bad) :
                             (bad && !(&o_err_count)) ? o_err_count + NB_ERRCNT'(1) : o_err_count;
        end

    // Expected next pattern, only meaningful while tracking
    always_comb o_expected = (state == TRACK) ? rot_held : '0;
endmodule

// File: tb/tb_led_seq_checker.sv
// tb_led_seq_checker: directed self-checking bench for led_seq_checker
module tb_led_seq_checker;
    logic clock = 1'b0;
    logic i_reset = 1'b0;
    logic [3:0] i_led = 4'b0001;
    logic i_valid = 1'b0;
    logic i_clear = 1'b0;
    logic o_locked, o_error, o_error_pulse;
    logic [15:0] o_step_count;
    logic [7:0] o_err_count;
    logic [3:0] o_expected;
    logic s_locked, s_error, s_error_pulse;
    logic [1:0] s_step_count, s_err_count;
    logic [3:0] s_expected;
    int n_checks = 0;
    int n_fail = 0;
    int pulses = 0;

    always #5 clock = ~clock;

    led_seq_checker u_dut (
        .clock(clock), .i_reset(i_reset), .i_led(i_led), .i_valid(i_valid), .i_clear(i_clear),
        .o_locked(o_locked), .o_error(o_error), .o_error_pulse(o_error_pulse),
        .o_step_count(o_step_count), .o_err_count(o_err_count), .o_expected(o_expected)
    );

    led_seq_checker #(.NB_STEPCNT(2), .NB_ERRCNT(2)) u_small (
        .clock(clock), .i_reset(i_reset), .i_led(i_led), .i_valid(i_valid), .i_clear(i_clear),
        .o_locked(s_locked), .o_error(s_error), .o_error_pulse(s_error_pulse),
        .o_step_count(s_step_count), .o_err_count(s_err_count), .o_expected(s_expected)
    );

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    // Strobe, then present the shifted pattern on the checking edge (optionally with clear)
    task automatic adv(input logic [3:0] nxt, input logic clr);
        i_valid = 1'b1;
        tick();
        i_led   = nxt;
        i_valid = 1'b0;
        i_clear = clr;
        tick();
        i_clear = 1'b0;
    endtask

    // Unstrobed glitch from a locked one-hot pattern, then relock on the same pattern
    task automatic glitch_relock;
        logic [3:0] p;
        p = i_led;
        i_led = p ^ 4'b0011;
        tick();
        pulses += int'(s_error_pulse);
        i_led = p;
        adv(p, 1'b0);
    endtask

    task automatic test_reset;
        #2;
        n_checks++;
        if ({o_locked, o_error, o_error_pulse, o_step_count, o_err_count, o_expected} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got lock=%b err=%b pul=%b step=%0d ec=%0d exp=%b, want all 0",
                     o_locked, o_error, o_error_pulse, o_step_count, o_err_count, o_expected);
        end
        tick();
        i_reset = 1'b1;
        tick();
    endtask

    task automatic test_lock_track;
        adv(4'b0001, 1'b0);
        n_checks++;
        if (o_locked !== 1'b1) begin n_fail++; $display("FAIL lock_first: got %b want 1", o_locked); end
        adv(4'b0010, 1'b0);
        adv(4'b0100, 1'b0);
        adv(4'b1000, 1'b0);
        adv(4'b0001, 1'b0);
        n_checks++;
        if (o_step_count !== 16'd4) begin n_fail++; $display("FAIL track_steps: got %0d want 4", o_step_count); end
        n_checks++;
        if (o_error !== 1'b0) begin n_fail++; $display("FAIL track_noerr: got %b want 0", o_error); end
        n_checks++;
        if (o_expected !== 4'b0010) begin n_fail++; $display("FAIL track_expected: got %b want 0010", o_expected); end
    endtask

    task automatic test_back_to_back;
        i_valid = 1'b1;
        tick();
        i_led = 4'b0010;
        tick();
        i_led   = 4'b0100;
        i_valid = 1'b0;
        tick();
        n_checks++;
        if (o_step_count !== 16'd6) begin n_fail++; $display("FAIL b2b_steps: got %0d want 6", o_step_count); end
        n_checks++;
        if (o_expected !== 4'b1000 || o_locked !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_state: got exp=%b lock=%b want 1000/1", o_expected, o_locked);
        end
        adv(4'b1000, 1'b0);
        adv(4'b0001, 1'b0);
        adv(4'b0010, 1'b0);
    endtask

    task automatic test_wrong_step;
        adv(4'b1000, 1'b0);
        n_checks++;
        if ({o_error_pulse, o_error, o_locked} !== 3'b110 || o_err_count !== 8'd1 || o_expected !== 4'b0000) begin
            n_fail++;
            $display("FAIL wrong_step: got pul=%b err=%b lock=%b ec=%0d exp=%b want 1/1/0/1/0000",
                     o_error_pulse, o_error, o_locked, o_err_count, o_expected);
        end
        tick();
        n_checks++;
        if (o_error_pulse !== 1'b0) begin n_fail++; $display("FAIL pulse_width: got %b want 0", o_error_pulse); end
        adv(4'b0100, 1'b0);
        n_checks++;
        if (o_locked !== 1'b1 || o_error !== 1'b1) begin
            n_fail++;
            $display("FAIL relock: got lock=%b err=%b want 1/1", o_locked, o_error);
        end
    endtask

    task automatic test_glitch;
        i_led = 4'b0110;
        tick();
        n_checks++;
        if (o_error_pulse !== 1'b1 || o_err_count !== 8'd2 || o_locked !== 1'b0) begin
            n_fail++;
            $display("FAIL glitch: got pul=%b ec=%0d lock=%b want 1/2/0", o_error_pulse, o_err_count, o_locked);
        end
        i_led = 4'b0100;
        tick();
        n_checks++;
        if (o_locked !== 1'b0) begin n_fail++; $display("FAIL glitch_nolock: got %b want 0", o_locked); end
    endtask

    task automatic test_idle_nonhot;
        i_clear = 1'b1;
        tick();
        i_clear = 1'b0;
        n_checks++;
        if (o_err_count !== 8'd0 || o_error !== 1'b0 || o_locked !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_idle: got ec=%0d err=%b lock=%b want 0/0/0", o_err_count, o_error, o_locked);
        end
        adv(4'b0000, 1'b0);
        adv(4'b0011, 1'b0);
        n_checks++;
        if (o_locked !== 1'b0 || o_err_count !== 8'd0 || o_error !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_nonhot: got lock=%b ec=%0d err=%b want 0/0/0", o_locked, o_err_count, o_error);
        end
    endtask

    task automatic test_clear_collision;
        adv(4'b0001, 1'b0);
        glitch_relock();
        glitch_relock();
        glitch_relock();
        adv(4'b0010, 1'b0);
        n_checks++;
        if (o_err_count !== 8'd3 || o_step_count !== 16'd1) begin
            n_fail++;
            $display("FAIL coll_setup: got ec=%0d step=%0d want 3/1", o_err_count, o_step_count);
        end
        adv(4'b1000, 1'b1);
        n_checks++;
        if (o_err_count !== 8'd1 || o_error !== 1'b1 || o_step_count !== 16'd0 || o_error_pulse !== 1'b1) begin
            n_fail++;
            $display("FAIL clear_collision: got ec=%0d err=%b step=%0d pul=%b want 1/1/0/1",
                     o_err_count, o_error, o_step_count, o_error_pulse);
        end
    endtask

    task automatic test_clear_step;
        adv(4'b0001, 1'b0);
        adv(4'b0010, 1'b1);
        n_checks++;
        if (o_step_count !== 16'd1 || o_err_count !== 8'd0 || o_error !== 1'b0 || o_locked !== 1'b1) begin
            n_fail++;
            $display("FAIL clear_step: got step=%0d ec=%0d err=%b lock=%b want 1/0/0/1",
                     o_step_count, o_err_count, o_error, o_locked);
        end
    endtask

    task automatic test_limits_reset;
        i_clear = 1'b1;
        tick();
        i_clear = 1'b0;
        adv(4'b0100, 1'b0);
        adv(4'b1000, 1'b0);
        adv(4'b0001, 1'b0);
        adv(4'b0010, 1'b0);
        adv(4'b0100, 1'b0);
        n_checks++;
        if (s_step_count !== 2'd1 || o_step_count !== 16'd5) begin
            n_fail++;
            $display("FAIL step_wrap: got small=%0d big=%0d want 1/5", s_step_count, o_step_count);
        end
        pulses = 0;
        for (int k = 0; k < 5; k++) glitch_relock();
        n_checks++;
        if (s_err_count !== 2'd3 || pulses !== 5) begin
            n_fail++;
            $display("FAIL err_sat: got count=%0d pulses=%0d want 3/5", s_err_count, pulses);
        end
        n_checks++;
        if (o_err_count !== 8'd5 || s_error !== 1'b1) begin
            n_fail++;
            $display("FAIL err_count5: got ec=%0d serr=%b want 5/1", o_err_count, s_error);
        end
        adv(4'b1000, 1'b0);
        n_checks++;
        if (o_locked !== 1'b1 || o_step_count !== 16'd6) begin
            n_fail++;
            $display("FAIL pre_reset: got lock=%b step=%0d want 1/6", o_locked, o_step_count);
        end
        #1 i_reset = 1'b0;
        #2;
        n_checks++;
        if ({o_locked, o_error, o_error_pulse, o_step_count, o_err_count, o_expected} !== '0 ||
            {s_locked, s_error, s_step_count, s_err_count} !== '0) begin
            n_fail++;
            $display("FAIL async_reset: got lock=%b err=%b step=%0d ec=%0d exp=%b want all 0",
                     o_locked, o_error, o_step_count, o_err_count, o_expected);
        end
        i_reset = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_lock_track();
        test_back_to_back();
        test_wrong_step();
        test_glitch();
        test_idle_nonhot();
        test_clear_collision();
        test_clear_step();
        test_limits_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
